// File: rtl/tmds_period_sequencer_if.sv
// Pixel/timing, encoder-control and TMDS word bundle for tmds_period_sequencer.
// master = timing generator / encoder side, slave = the sequencer itself.
interface tmds_period_sequencer_if;
  logic        vid_de;
  logic        vid_hs;
  logic        vid_vs;
  logic [23:0] vid_rgb;
  logic [23:0] enc_data;
  logic        enc_den;
  logic [1:0]  enc_ctrl0;
  logic [1:0]  enc_ctrl1;
  logic [1:0]  enc_ctrl2;
  logic [9:0]  tmds_in0;
  logic [9:0]  tmds_in1;
  logic [9:0]  tmds_in2;
  logic [9:0]  tmds_out0;
  logic [9:0]  tmds_out1;
  logic [9:0]  tmds_out2;
  logic        seq_err;

  modport master (
    output vid_de, vid_hs, vid_vs, vid_rgb, tmds_in0, tmds_in1, tmds_in2,
    input  enc_data, enc_den, enc_ctrl0, enc_ctrl1, enc_ctrl2,
    input  tmds_out0, tmds_out1, tmds_out2, seq_err
  );

  modport slave (
    input  vid_de, vid_hs, vid_vs, vid_rgb, tmds_in0, tmds_in1, tmds_in2,
    output enc_data, enc_den, enc_ctrl0, enc_ctrl1, enc_ctrl2,
    output tmds_out0, tmds_out1, tmds_out2, seq_err
  );
endinterface

// File: rtl/tmds_period_sequencer.sv
// TMDS period sequencer: delays raw video by PRE_LEN+GB_LEN, drives encoder controls,
// and (with HDMI_GUARD_EN defined) inserts the video preamble and leading guard band.
module tmds_period_sequencer #(
  parameter int PRE_LEN = 8,
  parameter int GB_LEN  = 2,
  parameter int ENC_LAT = 3
) (
  input logic                   clk,
  input logic                   rst,
  tmds_period_sequencer_if.slave bus
);
  localparam int         D       = PRE_LEN + GB_LEN;
  localparam logic [9:0] GB_CH02 = 10'b1011001100;
  localparam logic [9:0] GB_CH1  = 10'b0100110011;

  typedef struct packed {
    logic        de;
    logic        vs;
    logic        hs;
    logic [23:0] rgb;
  } vid_t;

  vid_t          raw;
  vid_t [D:1]    dly;
  logic [9:0]    tin0_q, tin1_q, tin2_q;
  logic [ENC_LAT-1:0] gb_pipe;
  logic          gb_req;
  logic          gb_d;
  logic [1:0]    ctrl1;
  logic          seq_err;

  assign raw = '{de: bus.vid_de, vs: bus.vid_vs, hs: bus.vid_hs, rgb: bus.vid_rgb};

  // NOTE: the delay line is a register chain, not a RAM, so it is cleared on reset
  // and cannot leak a stale burst into the encoders after rst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dly     <= '0;
      tin0_q  <= '0;
      tin1_q  <= '0;
      tin2_q  <= '0;
      gb_pipe <= '0;
    end else begin
      dly     <= {dly[D-1:1], raw};
      tin0_q  <= bus.tmds_in0;
      tin1_q  <= bus.tmds_in1;
      tin2_q  <= bus.tmds_in2;
      gb_pipe <= {gb_pipe[ENC_LAT-2:0], gb_req};
    end
  end

  // Guard request is aligned to the encoder pipeline so it overrides the two words
  // that leave the encoders just before the first pixel word.
  assign gb_d = gb_pipe[ENC_LAT-1];

`ifdef HDMI_GUARD_EN
  typedef enum logic [1:0] {CTRL, PREAMBLE, GUARD, VIDEO} state_t;

  state_t     state, state_nx;
  logic [3:0] cnt, cnt_nx;
  logic       vid_de_q;
  logic       raw_rise;
  logic       den_ending;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= CTRL;
      cnt      <= '0;
      vid_de_q <= 1'b0;
    end else begin
      state    <= state_nx;
      cnt      <= cnt_nx;
      vid_de_q <= bus.vid_de;
    end
  end

  assign raw_rise   = bus.vid_de & ~vid_de_q;
  // Delayed DE is about to drop when the stage feeding the output is already low.
  assign den_ending = ~dly[D-1].de;

  // NOTE: every output of this block gets a default first, so no path infers a latch.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    gb_req   = 1'b0;
    unique case (state)
      CTRL: begin
        if (raw_rise) begin
          state_nx = PREAMBLE;
          cnt_nx   = '0;
        end
      end
      PREAMBLE: begin
        cnt_nx = cnt + 4'd1;
        if (cnt == 4'(PRE_LEN - 1)) begin
          state_nx = GUARD;
          cnt_nx   = '0;
        end
      end
      GUARD: begin
        gb_req = 1'b1;
        cnt_nx = cnt + 4'd1;
        if (cnt == 4'(GB_LEN - 1)) begin
          state_nx = VIDEO;
          cnt_nx   = '0;
        end
      end
      VIDEO: begin
        if (den_ending) begin
          state_nx = raw_rise ? PREAMBLE : CTRL;
          cnt_nx   = '0;
        end
      end
      default: state_nx = CTRL;
    endcase
  end

  // A rise that cannot start a preamble passes through unguarded and is flagged.
  assign seq_err = raw_rise & ~((state == CTRL) | ((state == VIDEO) & den_ending));
  assign ctrl1   = (state == PREAMBLE) ? 2'b01 : 2'b00;
`else
  assign gb_req  = 1'b0;
  assign seq_err = 1'b0;
  assign ctrl1   = 2'b00;
`endif

  assign bus.enc_data  = dly[D].rgb;
  assign bus.enc_den   = dly[D].de;
  assign bus.enc_ctrl0 = {dly[D].vs, dly[D].hs};
  assign bus.enc_ctrl1 = ctrl1;
  assign bus.enc_ctrl2 = 2'b00;
  assign bus.seq_err   = seq_err;

  assign bus.tmds_out0 = gb_d ? GB_CH02 : tin0_q;
  assign bus.tmds_out1 = gb_d ? GB_CH1  : tin1_q;
  assign bus.tmds_out2 = gb_d ? GB_CH02 : tin2_q;
endmodule

// File: tb/tb_tmds_period_sequencer.sv
// Randomized bench for tmds_period_sequencer against a cycle-history reference model.
// Builds for DVI by default; define HDMI_GUARD_EN to also expect preamble/guard behaviour.
module tb_tmds_period_sequencer;
  localparam int D    = 10;
  localparam int MAXC = 8192;
`ifdef HDMI_GUARD_EN
  localparam bit HDMI = 1'b1;
`else
  localparam bit HDMI = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  tmds_period_sequencer_if bus ();

  tmds_period_sequencer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;
  int epoch       = 0;
  int last_acc    = -1000;

  bit          de_h  [MAXC];
  bit          hs_h  [MAXC];
  bit          vs_h  [MAXC];
  logic [23:0] rgb_h [MAXC];
  logic [29:0] tin_h [MAXC];
  bit          acc_h [MAXC];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s cycle %0d: got %0h, expected %0h", tag, cyc, got, exp);
    end
  endtask

  // History accessors: anything before the last reset release reads as zero.
  function automatic bit raw_de(int i);
    return (i >= epoch) ? de_h[i] : 1'b0;
  endfunction
  function automatic logic [26:0] raw_vid(int i);
    return (i >= epoch) ? {de_h[i], vs_h[i], hs_h[i], rgb_h[i]} : 27'd0;
  endfunction
  function automatic bit acc_at(int i);
    return (i >= epoch) ? acc_h[i] : 1'b0;
  endfunction

  // A guarded burst occupies the sequencer from its rise until its delayed DE is
  // about to leave the delay line, and never ends before preamble+guard are done.
  function automatic bit seq_free(int c);
    if (last_acc < epoch) return 1'b1;
    for (int k = last_acc + D + 1; k <= c; k++)
      if (!raw_de(k - (D - 1))) return 1'b1;
    return 1'b0;
  endfunction

  task automatic check_cycle();
    bit          rise, ok, guard, pre;
    logic [26:0] v;
    logic [29:0] tw;
    rise = raw_de(cyc) && !raw_de(cyc - 1);
    ok   = HDMI && rise && seq_free(cyc);
    acc_h[cyc] = ok;
    if (ok) last_acc = cyc;

    v = raw_vid(cyc - D);
    pre = 1'b0;
    for (int k = 1; k <= 8; k++) pre |= acc_at(cyc - k);
    guard = acc_at(cyc - 12) || acc_at(cyc - 13);
    tw = (cyc - 1 >= epoch) ? tin_h[cyc - 1] : 30'd0;
    if (guard) tw = {10'b1011001100, 10'b0100110011, 10'b1011001100};

    check("enc_den",   32'(bus.enc_den),   32'(v[26]));
    check("enc_data",  32'(bus.enc_data),  32'(v[23:0]));
    check("enc_ctrl0", 32'(bus.enc_ctrl0), 32'(v[25:24]));
    check("enc_ctrl1", 32'(bus.enc_ctrl1), pre ? 32'd1 : 32'd0);
    check("enc_ctrl2", 32'(bus.enc_ctrl2), 32'd0);
    check("tmds_out0", 32'(bus.tmds_out0), 32'(tw[9:0]));
    check("tmds_out1", 32'(bus.tmds_out1), 32'(tw[19:10]));
    check("tmds_out2", 32'(bus.tmds_out2), 32'(tw[29:20]));
    check("seq_err",   32'(bus.seq_err),   32'(HDMI && rise && !ok));
  endtask

  // One pixel period, entered and left at a falling clock edge.
  task automatic step(input bit de, input logic [23:0] rgb);
    if (cyc >= MAXC) begin
      $display("FAIL cycle_budget: got %0d cycles, limit %0d", cyc, MAXC);
      $fatal(1);
    end
    bus.vid_de   = de;
    bus.vid_hs   = 1'($urandom);
    bus.vid_vs   = 1'($urandom);
    bus.vid_rgb  = rgb;
    bus.tmds_in0 = 10'($urandom);
    bus.tmds_in1 = 10'($urandom);
    bus.tmds_in2 = 10'($urandom);
    de_h[cyc]  = de;
    hs_h[cyc]  = bus.vid_hs;
    vs_h[cyc]  = bus.vid_vs;
    rgb_h[cyc] = rgb;
    tin_h[cyc] = {bus.tmds_in2, bus.tmds_in1, bus.tmds_in0};
    #1;
    check_cycle();
    cyc++;
    @(negedge clk);
  endtask

  task automatic run(input bit de, input int n);
    for (int i = 0; i < n; i++) step(de, 24'($urandom));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.vid_de = 1'b0;
    bus.vid_hs = 1'b0;
    bus.vid_vs = 1'b0;
    bus.vid_rgb = '0;
    bus.tmds_in0 = '0;
    bus.tmds_in1 = '0;
    bus.tmds_in2 = '0;
    #1;
    check("rst_enc_den",   32'(bus.enc_den),   32'd0);
    check("rst_enc_data",  32'(bus.enc_data),  32'd0);
    check("rst_enc_ctrl0", 32'(bus.enc_ctrl0), 32'd0);
    check("rst_enc_ctrl1", 32'(bus.enc_ctrl1), 32'd0);
    check("rst_tmds_out0", 32'(bus.tmds_out0), 32'd0);
    check("rst_tmds_out1", 32'(bus.tmds_out1), 32'd0);
    check("rst_tmds_out2", 32'(bus.tmds_out2), 32'd0);
    check("rst_seq_err",   32'(bus.seq_err),   32'd0);
    repeat (2) @(negedge clk);
    rst   = 1'b0;
    epoch = cyc;
  endtask

  initial begin
    @(negedge clk);
    do_reset();

    // Isolated burst whose first pixel is a known value.
    run(1'b0, 15);
    step(1'b1, 24'hA53C0F);
    run(1'b1, 19);
    // Second burst arriving after only 4 idle cycles.
    run(1'b0, 4);
    run(1'b1, 25);
    run(1'b0, 15);
    // Pulses shorter than the delay depth.
    run(1'b1, 1);
    run(1'b0, 14);
    run(1'b1, 3);
    run(1'b0, 14);
    // Gap of D-1: delayed fall and the next raw rise land in the same cycle.
    run(1'b1, 20);
    run(1'b0, D - 1);
    run(1'b1, 20);
    run(1'b0, 15);

    for (int b = 0; b < 60; b++) begin
      run(1'b1, int'($urandom_range(1, 30)));
      run(1'b0, int'($urandom_range(1, 20)));
    end

    // Reset while VIDEO is running, then a fresh burst.
    run(1'b0, 15);
    run(1'b1, 15);
    do_reset();
    run(1'b0, 14);
    run(1'b1, 20);
    run(1'b0, 20);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
